// File: rtl/add_sub_seq_if.sv
// -----------------------------------------------------------------------------
// add_sub_seq_if
// Handshake bundle for the digit-serial adder/subtractor.
//   Request side : in_valid, in_ready, A, B, M (M=0 add, M=1 subtract A-B)
//   Response side: out_valid, out_ready, S, C, V, Z
// Modports:
//   master - the producer/consumer talking to the block (drives operands,
//            accepts results)
//   slave  - the add_sub_seq block itself
// -----------------------------------------------------------------------------
interface add_sub_seq_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             M;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] S;
    logic             C;
    logic             V;
    logic             Z;

    modport master (
        output in_valid,
        input  in_ready,
        output A,
        output B,
        output M,
        input  out_valid,
        output out_ready,
        input  S,
        input  C,
        input  V,
        input  Z
    );

    modport slave (
        input  in_valid,
        output in_ready,
        input  A,
        input  B,
        input  M,
        output out_valid,
        input  out_ready,
        output S,
        output C,
        output V,
        output Z
    );
endinterface

// File: rtl/add_sub_seq.sv
// -----------------------------------------------------------------------------
// add_sub_seq
// Multi-cycle digit-serial adder/subtractor. Operands are accepted in IDLE,
// processed DIGIT bits per clock in RUN (WIDTH/DIGIT cycles), and the result
// is presented in DONE until the consumer accepts it.
//
// Parameters:
//   WIDTH - operand/result width (>= 2, integer multiple of DIGIT)
//   DIGIT - bits processed per RUN cycle (1..WIDTH)
//
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous, active-low reset
//   bus   - add_sub_seq_if.slave: in_valid/in_ready/A/B/M request,
//           out_valid/out_ready/S/C/V/Z response
//
// Optional feature (macro ADD_SUB_SAT_EN):
//   When defined, a signed overflow saturates S to signed max/min. When
//   undefined, S wraps modulo 2^WIDTH and no saturation logic is built.
// -----------------------------------------------------------------------------
module add_sub_seq #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    add_sub_seq_if.slave bus
);

    localparam int N     = WIDTH / DIGIT;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-1:0] r_res;
    logic             r_carry;
    logic [CNT_W-1:0] r_cnt;
    logic             r_a_msb;
    logic             r_b_msb;
    logic             r_in_ready;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_s;
    logic             r_c;
    logic             r_v;
    logic             r_z;

    logic [DIGIT:0]   w_digit_sum;
    logic [WIDTH-1:0] w_res_next;
    logic             w_v;
    logic [WIDTH-1:0] w_s_final;
    logic             w_z;

    // One digit of ripple: low DIGIT bits of each shifter plus the running carry.
    assign w_digit_sum = {1'b0, r_a_sh[DIGIT-1:0]}
                       + {1'b0, r_b_sh[DIGIT-1:0]}
                       + {{DIGIT{1'b0}}, r_carry};

    // The new digit enters at the MSB end so that after N shifts the first
    // (least significant) digit has arrived at bit 0.
    generate
        if (DIGIT == WIDTH) begin : g_single_digit
            assign w_res_next = w_digit_sum[DIGIT-1:0];
        end else begin : g_multi_digit
            assign w_res_next = {w_digit_sum[DIGIT-1:0], r_res[WIDTH-1:DIGIT]};
        end
    endgenerate

    // Overflow: both effective operands share a sign and the result sign differs.
    // Only meaningful on the final RUN cycle, which is the only place it is used.
    assign w_v = (r_a_msb == r_b_msb) && (w_res_next[WIDTH-1] != r_a_msb);

`ifdef ADD_SUB_SAT_EN
    // Clamp toward the sign of the operands: positive overflow -> signed max,
    // negative overflow -> signed min.
    assign w_s_final = w_v ? (r_a_msb ? {1'b1, {(WIDTH-1){1'b0}}}
                                      : {1'b0, {(WIDTH-1){1'b1}}})
                           : w_res_next;
`else
    assign w_s_final = w_res_next;
`endif

    assign w_z = (w_s_final == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_a_sh      <= '0;
            r_b_sh      <= '0;
            r_res       <= '0;
            r_carry     <= 1'b0;
            r_cnt       <= '0;
            r_a_msb     <= 1'b0;
            r_b_msb     <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_s         <= '0;
            r_c         <= 1'b0;
            r_v         <= 1'b0;
            r_z         <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        // Subtraction is A + ~B + 1: invert B here and seed
                        // the carry with M.
                        r_a_sh     <= bus.A;
                        r_b_sh     <= bus.B ^ {WIDTH{bus.M}};
                        r_carry    <= bus.M;
                        r_cnt      <= '0;
                        r_a_msb    <= bus.A[WIDTH-1];
                        r_b_msb    <= bus.B[WIDTH-1] ^ bus.M;
                        r_in_ready <= 1'b0;
                        r_state    <= ST_RUN;
                    end
                end

                ST_RUN: begin
                    r_a_sh  <= r_a_sh >> DIGIT;
                    r_b_sh  <= r_b_sh >> DIGIT;
                    r_res   <= w_res_next;
                    r_carry <= w_digit_sum[DIGIT];
                    r_cnt   <= r_cnt + CNT_W'(1);
                    if (r_cnt == CNT_LAST) begin
                        // Flags are captured together with the last digit so
                        // they are valid the same cycle out_valid rises.
                        r_s         <= w_s_final;
                        r_c         <= w_digit_sum[DIGIT];
                        r_v         <= w_v;
                        r_z         <= w_z;
                        r_out_valid <= 1'b1;
                        r_state     <= ST_DONE;
                    end
                end

                ST_DONE: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end

                default: begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.S         = r_s;
    assign bus.C         = r_c;
    assign bus.V         = r_v;
    assign bus.Z         = r_z;

endmodule

// File: tb/tb_add_sub_seq.sv
// -----------------------------------------------------------------------------
// tb_add_sub_seq
// Scoreboard bench for add_sub_seq (WIDTH=8, DIGIT=2). The driver pushes the
// expected result of each accepted operation into a queue; an independent
// monitor pops and compares on every output handshake.
// -----------------------------------------------------------------------------
module tb_add_sub_seq;

    localparam int W = 8;
    localparam int D = 2;
    localparam int N = W / D;

    typedef struct packed {
        logic [W-1:0] s;
        logic         c;
        logic         v;
        logic         z;
    } exp_t;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    bit   hold_rdy;
    exp_t exp_q[$];

    add_sub_seq_if #(.WIDTH(W)) bus ();

    add_sub_seq #(.WIDTH(W), .DIGIT(D)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain integer arithmetic on unsigned and signed views.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic m);
        exp_t e;
        int ua, ub, sa, sb, ru, rs;
        ua = int'(a);
        ub = int'(b);
        sa = int'($signed(a));
        sb = int'($signed(b));
        if (!m) begin
            ru  = ua + ub;
            rs  = sa + sb;
            e.c = (ru > 255);
        end else begin
            ru  = ua - ub;
            rs  = sa - sb;
            e.c = (ua >= ub);
        end
        e.s = ru[W-1:0];
        e.v = (rs > 127) || (rs < -128);
`ifdef ADD_SUB_SAT_EN
        if (e.v) e.s = (rs > 127) ? 8'h7F : 8'h80;
`endif
        e.z = (e.s == '0);
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Monitor: a handshake completes on the next rising edge.
    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            exp_t e;
            exp_t a;
            a = '{s: bus.S, c: bus.C, v: bus.V, z: bus.Z};
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_result: got S=%0h C=%0b V=%0b Z=%0b expected none", a.s, a.c, a.v, a.z);
            end else begin
                e = exp_q.pop_front();
                if (a !== e) begin
                    bad++;
                    $display("FAIL result: got S=%0h C=%0b V=%0b Z=%0b expected S=%0h C=%0b V=%0b Z=%0b",
                             a.s, a.c, a.v, a.z, e.s, e.c, e.v, e.z);
                end else begin
                    $display("result S=%0h C=%0b V=%0b Z=%0b ok", a.s, a.c, a.v, a.z);
                end
            end
        end
    end

    // Random backpressure unless a test takes control of out_ready.
    always @(posedge clk) begin
        #1;
        if (!hold_rdy) bus.out_ready = 1'($urandom_range(0, 1));
    end

    task automatic wait_in_ready();
        int n;
        n = 0;
        while (!bus.in_ready && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!bus.in_ready) chk("in_ready_timeout", 32'(bus.in_ready), 32'd1);
    endtask

    // Issue one operation and check out_valid timing over the next N edges.
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic m);
        wait_in_ready();
        bus.A        = a;
        bus.B        = b;
        bus.M        = m;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        exp_q.push_back(model(a, b, m));
        $display("issue A=%0h B=%0h M=%0b", a, b, m);
        chk("in_ready_busy", 32'(bus.in_ready), 32'd0);
        for (int i = 1; i <= N; i++) begin
            @(posedge clk);
            #1;
            chk("latency_out_valid", 32'(bus.out_valid), (i == N) ? 32'd1 : 32'd0);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || !bus.in_ready) && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_timeout", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        exp_t snap;
        total        = 0;
        bad          = 0;
        hold_rdy     = 1'b0;
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.A        = '0;
        bus.B        = '0;
        bus.M        = 1'b0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_S", 32'(bus.S), 32'd0);
        chk("rst_CVZ", 32'({bus.C, bus.V, bus.Z}), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed cases
        send(8'h01, 8'h00, 1'b0);
        send(8'h0C, 8'h07, 1'b1);
        send(8'h05, 8'h05, 1'b1);
        send(8'h7F, 8'h01, 1'b0);
        send(8'h00, 8'h01, 1'b1);
        send(8'h80, 8'h01, 1'b1);
        send(8'hFF, 8'hFF, 1'b0);
        send(8'h80, 8'h80, 1'b0);
        drain();

        // Stall in DONE while pulsing in_valid with operands that must be ignored.
        hold_rdy = 1'b1;
        bus.out_ready = 1'b0;
        send(8'h33, 8'h44, 1'b0);
        snap = '{s: bus.S, c: bus.C, v: bus.V, z: bus.Z};
        chk("stall_value", 32'(snap), 32'(model(8'h33, 8'h44, 1'b0)));
        for (int i = 0; i < 3; i++) begin
            bus.A        = 8'($urandom);
            bus.B        = 8'($urandom);
            bus.M        = 1'($urandom);
            bus.in_valid = 1'b1;
            @(posedge clk);
            #1;
            chk("stall_hold", 32'({bus.S, bus.C, bus.V, bus.Z}), 32'(snap));
            chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
            chk("stall_out_valid", 32'(bus.out_valid), 32'd1);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("release_in_ready", 32'(bus.in_ready), 32'd1);
        chk("release_out_valid", 32'(bus.out_valid), 32'd0);
        bus.out_ready = 1'b0;
        hold_rdy = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("no_queued_op", 32'(bus.out_valid), 32'd0);

        // Reset two cycles into RUN abandons the operation.
        wait_in_ready();
        bus.A = 8'h12; bus.B = 8'h34; bus.M = 1'b0; bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrun_rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("midrun_rst_S", 32'(bus.S), 32'd0);
        chk("midrun_rst_in_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send(8'hFF, 8'h01, 1'b0);
        drain();

        // Randomised traffic with random backpressure.
        for (int i = 0; i < 150; i++) begin
            send(8'($urandom), 8'($urandom), 1'($urandom));
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
